// File: rtl/light_conflict_monitor.sv
// light_conflict_monitor
// Safety stage between the four-way traffic controller and the lamp drivers.
// Legal light patterns pass through with one cycle of latency. The first
// violation latches a fault code/direction and switches the lamps to all-way
// flashing red until the operator clears it, after which the monitor waits
// for a stable legal pattern before passing lights again.
//
// Handshake: none. Every posedge samples all four light vectors as one
// pattern; there is no valid/ready, and each cycle is one sample.
module light_conflict_monitor #(
    parameter int MIN_GREEN   = 8,
    parameter int MIN_YELLOW  = 4,
    parameter int MAX_ALL_RED = 2,
    parameter int FLASH_HALF  = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    input  logic       fault_clr,
    output logic [2:0] n_lamp,
    output logic [2:0] s_lamp,
    output logic [2:0] e_lamp,
    output logic [2:0] w_lamp,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_RESYNC  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FLASH   = 2'd2
    } state_t;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [3:0][2:0] ALL_RED = {4{RED}};
    localparam logic [3:0][2:0] ALL_OFF = '0;

    localparam int FL_W = $clog2(FLASH_HALF + 1);
    localparam logic [FL_W-1:0]  FL_HALF_C = FL_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_AR_C  = CNT_W'(MAX_ALL_RED);

    // index 0..3 = N, S, E, W
    logic [3:0][2:0]       cur;
    logic [3:0][2:0]       prev_q, prev_d;
    logic [3:0][2:0]       lamp_q, lamp_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]      ar_q, ar_d;
    logic [3:0]            armed_q, armed_d;
    logic [FL_W-1:0]       fl_cnt_q, fl_cnt_d;
    logic                  fl_off_q, fl_off_d;
    logic                  fault_q, fault_d;
    logic [2:0]            code_q, code_d;
    logic [1:0]            dir_q, dir_d;
    state_t                state_q, state_d;

    logic [3:0] bad_enc, bad_trans, short_g, short_y;
    logic [2:0] non_red_cnt;
    logic       all_red, ar_timeout, sync_ok;
    logic       viol;
    logic [2:0] viol_code;
    logic [1:0] viol_dir;

    assign cur = {w_lights, e_lights, s_lights, n_lights};

    function automatic logic is_legal(input logic [2:0] v);
        return (v == GREEN) || (v == YELLOW) || (v == RED);
    endfunction

    function automatic logic trans_ok(input logic [2:0] a, input logic [2:0] b);
        return (a == b) || (a == GREEN && b == YELLOW) ||
               (a == YELLOW && b == RED) || (a == RED && b == GREEN);
    endfunction

    function automatic logic [1:0] first_dir(input logic [3:0] v);
        if (v[0]) return 2'd0;
        if (v[1]) return 2'd1;
        if (v[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Per-direction rule checks of the current sample against the previous one
    always_comb begin
        bad_enc     = '0;
        bad_trans   = '0;
        short_g     = '0;
        short_y     = '0;
        non_red_cnt = '0;
        for (int d = 0; d < 4; d++) begin
            bad_enc[d] = !is_legal(cur[d]);
            if (cur[d] != RED) non_red_cnt = non_red_cnt + 3'd1;
            bad_trans[d] = !bad_enc[d] && !trans_ok(prev_q[d], cur[d]);
            short_g[d] = armed_q[d] && (prev_q[d] == GREEN) && (cur[d] == YELLOW) &&
                         (cnt_q[d] < MIN_G_C);
            short_y[d] = armed_q[d] && (prev_q[d] == YELLOW) && (cur[d] == RED) &&
                         (cnt_q[d] < MIN_Y_C);
        end
    end

    assign all_red    = (non_red_cnt == 3'd0);
    // ar_q counts the all-red run up to the previous sample; this sample extends it
    assign ar_timeout = all_red && (ar_q >= MAX_AR_C);
    assign sync_ok    = !(|bad_enc) && (non_red_cnt == 3'd1) && (cur == prev_q);

    // Prioritise violations: lowest code first, then lowest direction
    always_comb begin
        viol      = 1'b1;
        viol_code = 3'd0;
        viol_dir  = 2'd0;
        if (|bad_enc) begin
            viol_code = 3'd1;
            viol_dir  = first_dir(bad_enc);
        end else if (non_red_cnt > 3'd1) begin
            viol_code = 3'd2;
        end else if (|bad_trans) begin
            viol_code = 3'd3;
            viol_dir  = first_dir(bad_trans);
        end else if (|short_g) begin
            viol_code = 3'd4;
            viol_dir  = first_dir(short_g);
        end else if (|short_y) begin
            viol_code = 3'd5;
            viol_dir  = first_dir(short_y);
        end else if (ar_timeout) begin
            viol_code = 3'd6;
        end else begin
            viol = 1'b0;
        end
    end

    // Next-state and registered-output logic for the monitor FSM
    always_comb begin
        state_d  = state_q;
        prev_d   = cur;
        lamp_d   = lamp_q;
        cnt_d    = cnt_q;
        ar_d     = ar_q;
        armed_d  = armed_q;
        fl_cnt_d = fl_cnt_q;
        fl_off_d = fl_off_q;
        fault_d  = fault_q;
        code_d   = code_q;
        dir_d    = dir_q;
        case (state_q)
            ST_RESYNC: begin
                lamp_d  = ALL_RED;
                armed_d = '0;
                if (sync_ok) begin
                    state_d = ST_MONITOR;
                    lamp_d  = cur;
                    for (int d = 0; d < 4; d++) cnt_d[d] = CNT_W'(1);
                    ar_d = '0;
                end
            end
            ST_MONITOR: begin
                if (viol) begin
                    state_d  = ST_FLASH;
                    lamp_d   = ALL_RED;
                    fault_d  = 1'b1;
                    code_d   = viol_code;
                    dir_d    = viol_dir;
                    fl_cnt_d = FL_W'(1);
                    fl_off_d = 1'b0;
                end else begin
                    lamp_d = cur;
                    for (int d = 0; d < 4; d++) begin
                        if (cur[d] == prev_q[d])
                            cnt_d[d] = (cnt_q[d] == CNT_MAX) ? CNT_MAX : cnt_q[d] + CNT_W'(1);
                        else
                            cnt_d[d] = CNT_W'(1);
                        if (prev_q[d] == RED && cur[d] == GREEN) armed_d[d] = 1'b1;
                    end
                    if (all_red)
                        ar_d = (ar_q == CNT_MAX) ? CNT_MAX : ar_q + CNT_W'(1);
                    else
                        ar_d = '0;
                end
            end
            ST_FLASH: begin
                if (fault_clr) begin
                    state_d  = ST_RESYNC;
                    prev_d   = ALL_RED;
                    lamp_d   = ALL_RED;
                    fault_d  = 1'b0;
                    code_d   = 3'd0;
                    dir_d    = 2'd0;
                    fl_cnt_d = '0;
                    fl_off_d = 1'b0;
                end else if (fl_cnt_q >= FL_HALF_C) begin
                    fl_off_d = !fl_off_q;
                    fl_cnt_d = FL_W'(1);
                    lamp_d   = fl_off_q ? ALL_RED : ALL_OFF;
                end else begin
                    fl_cnt_d = fl_cnt_q + FL_W'(1);
                end
            end
            default: begin
                state_d = ST_RESYNC;
                lamp_d  = ALL_RED;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state_q  <= ST_RESYNC;
            prev_q   <= ALL_RED;
            lamp_q   <= ALL_RED;
            cnt_q    <= '0;
            ar_q     <= '0;
            armed_q  <= '0;
            fl_cnt_q <= '0;
            fl_off_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
            dir_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            lamp_q   <= lamp_d;
            cnt_q    <= cnt_d;
            ar_q     <= ar_d;
            armed_q  <= armed_d;
            fl_cnt_q <= fl_cnt_d;
            fl_off_q <= fl_off_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            dir_q    <= dir_d;
        end
    end

    assign n_lamp     = lamp_q[0];
    assign s_lamp     = lamp_q[1];
    assign e_lamp     = lamp_q[2];
    assign w_lamp     = lamp_q[3];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_dir  = dir_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb_light_conflict_monitor
// Directed stimulus for light_conflict_monitor. A behavioural model tracks run
// lengths, arming and time-since-fault and predicts lamps/fault outputs every
// cycle; directed tests add literal expectations at the interesting edges.
module tb_light_conflict_monitor;

    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] RED = 3'b100;
    localparam int MIN_GREEN   = 8;
    localparam int MIN_YELLOW  = 4;
    localparam int MAX_ALL_RED = 2;
    localparam int FLASH_HALF  = 4;
    localparam int CNT_SAT     = 255;

    logic       clk;
    logic       rst_a;
    logic [2:0] n_l, s_l, e_l, w_l;
    logic       fault_clr;
    logic [2:0] n_lamp, s_lamp, e_lamp, w_lamp;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic [1:0] state_dbg;
    logic [11:0] lamps;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  check_en = 0;

    light_conflict_monitor dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .n_lights   (n_l),
        .s_lights   (s_l),
        .e_lights   (e_l),
        .w_lights   (w_l),
        .fault_clr  (fault_clr),
        .n_lamp     (n_lamp),
        .s_lamp     (s_lamp),
        .e_lamp     (e_lamp),
        .w_lamp     (w_lamp),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_dir  (fault_dir),
        .state_dbg  (state_dbg)
    );

    assign lamps = {w_lamp, e_lamp, s_lamp, n_lamp};

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode = 0;  // 0 waiting for stable pattern, 1 passing, 2 flashing
    logic [2:0] m_prev [4] = '{RED, RED, RED, RED};
    int         m_run  [4] = '{0, 0, 0, 0};
    bit         m_armed[4] = '{0, 0, 0, 0};
    int         m_ar = 0;
    int         m_t  = 0;
    logic [2:0] m_lamp [4] = '{RED, RED, RED, RED};
    logic       m_fault = 0;
    logic [2:0] m_code  = 0;
    logic [1:0] m_dir   = 0;

    function automatic bit legal3(input logic [2:0] v);
        return v == GRN || v == YEL || v == RED;
    endfunction

    function automatic bit step_ok(input logic [2:0] a, input logic [2:0] b);
        return a == b || (a == GRN && b == YEL) || (a == YEL && b == RED) || (a == RED && b == GRN);
    endfunction

    always @(posedge clk) begin : model
        logic [2:0] c [4];
        int  nonred, code, dir;
        bit  hit, all_legal, same;
        c[0] = n_l; c[1] = s_l; c[2] = e_l; c[3] = w_l;
        nonred = 0; all_legal = 1; same = 1;
        for (int d = 0; d < 4; d++) begin
            if (c[d] != RED) nonred++;
            if (!legal3(c[d])) all_legal = 0;
            if (c[d] != m_prev[d]) same = 0;
        end
        if (!rst_a) begin
            m_mode = 0; m_ar = 0; m_t = 0;
            m_fault = 0; m_code = 0; m_dir = 0;
            for (int d = 0; d < 4; d++) begin
                m_prev[d] = RED; m_run[d] = 0; m_armed[d] = 0; m_lamp[d] = RED;
            end
        end else if (m_mode == 0) begin
            for (int d = 0; d < 4; d++) begin m_lamp[d] = RED; m_armed[d] = 0; end
            if (same && all_legal && nonred == 1) begin
                m_mode = 1; m_ar = 0;
                for (int d = 0; d < 4; d++) begin m_lamp[d] = c[d]; m_run[d] = 1; end
            end
            for (int d = 0; d < 4; d++) m_prev[d] = c[d];
        end else if (m_mode == 1) begin
            code = 0; dir = 0;
            for (int k = 1; k <= 6 && code == 0; k++) begin
                for (int d = 0; d < 4 && code == 0; d++) begin
                    case (k)
                        1: hit = !legal3(c[d]);
                        2: hit = nonred > 1;
                        3: hit = !step_ok(m_prev[d], c[d]);
                        4: hit = m_armed[d] && m_prev[d] == GRN && c[d] == YEL && m_run[d] < MIN_GREEN;
                        5: hit = m_armed[d] && m_prev[d] == YEL && c[d] == RED && m_run[d] < MIN_YELLOW;
                        default: hit = nonred == 0 && m_ar + 1 >= MAX_ALL_RED + 1;
                    endcase
                    if (hit) begin
                        code = k;
                        dir  = (k == 2 || k == 6) ? 0 : d;
                    end
                end
            end
            if (code != 0) begin
                m_mode = 2; m_t = 0; m_fault = 1;
                m_code = 3'(code); m_dir = 2'(dir);
                for (int d = 0; d < 4; d++) m_lamp[d] = RED;
            end else begin
                for (int d = 0; d < 4; d++) begin
                    m_lamp[d] = c[d];
                    if (c[d] == m_prev[d]) m_run[d] = (m_run[d] + 1 > CNT_SAT) ? CNT_SAT : m_run[d] + 1;
                    else m_run[d] = 1;
                    if (m_prev[d] == RED && c[d] == GRN) m_armed[d] = 1;
                end
                m_ar = (nonred == 0) ? m_ar + 1 : 0;
            end
            for (int d = 0; d < 4; d++) m_prev[d] = c[d];
        end else begin
            if (fault_clr) begin
                m_mode = 0; m_fault = 0; m_code = 0; m_dir = 0; m_t = 0;
                for (int d = 0; d < 4; d++) begin m_lamp[d] = RED; m_prev[d] = RED; end
            end else begin
                m_t++;
                for (int d = 0; d < 4; d++) m_lamp[d] = ((m_t / FLASH_HALF) % 2 == 0) ? RED : 3'b000;
                for (int d = 0; d < 4; d++) m_prev[d] = c[d];
            end
        end
    end

    // scoreboard compare: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_lamps", 32'(lamps), 32'({m_lamp[3], m_lamp[2], m_lamp[1], m_lamp[0]}));
            check("cmp_fault", 32'(fault), 32'(m_fault));
            check("cmp_code",  32'(fault_code), 32'(m_code));
            check("cmp_dir",   32'(fault_dir), 32'(m_dir));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [11:0] pat(input int d, input logic [2:0] c);
        logic [3:0][2:0] p;
        p = {4{RED}};
        p[d] = c;
        return p;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [11:0] p);
        n_l = p[2:0]; s_l = p[5:3]; e_l = p[8:6]; w_l = p[11:9];
        cycle();
    endtask

    task automatic hold(input logic [11:0] p, input int k);
        repeat (k) drive(p);
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        drive({4{RED}});
        fault_clr = 1'b0;
    endtask

    task automatic sync_north();
        hold(pat(0, GRN), 2);
    endtask

    task automatic expect_fault(input string name, input logic [2:0] code, input logic [1:0] dir);
        check({name, "_fault"}, 32'(fault), 32'd1);
        check({name, "_code"}, 32'(fault_code), 32'(code));
        check({name, "_dir"}, 32'(fault_dir), 32'(dir));
        check({name, "_lamps"}, 32'(lamps), 32'h924);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [11:0] p;
        rst_a = 1'b0; fault_clr = 1'b0;
        n_l = RED; s_l = RED; e_l = RED; w_l = RED;
        cycle();
        check_en = 1;
        cycle();
        rst_a = 1'b1;
        check("reset_lamps", 32'(lamps), 32'h924);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_code",  32'(fault_code), 32'd0);

        // T1: normal controller cycle, three rounds
        drive(pat(0, GRN));
        check("t1_resync_hold", 32'(lamps), 32'h924);
        drive(pat(0, GRN));
        check("t1_sync_lamp", 32'(lamps), 32'(pat(0, GRN)));
        hold(pat(0, GRN), 6);
        hold(pat(0, YEL), 4);
        for (int d = 1; d < 4; d++) begin
            hold(pat(d, GRN), MIN_GREEN);
            hold(pat(d, YEL), MIN_YELLOW);
        end
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                hold(pat(d, GRN), MIN_GREEN);
                hold(pat(d, YEL), MIN_YELLOW);
            end
        end
        check("t1_no_fault", 32'(fault), 32'd0);

        // T2: north and south green together, then flash pattern
        p = pat(0, GRN); p[5:3] = GRN;
        drive(p);
        expect_fault("t2", 3'd2, 2'd0);
        for (int i = 1; i < 16; i++) begin
            drive(p);
            check("t2_flash", 32'(lamps), ((i / 4) % 2 == 1) ? 32'h000 : 32'h924);
        end
        check("t2_code_held", 32'(fault_code), 32'd2);

        // T6a: operator clear, then resync needs two equal samples
        clear_fault();
        check("t6_clr_fault", 32'(fault), 32'd0);
        check("t6_clr_code", 32'(fault_code), 32'd0);
        drive(pat(0, GRN));
        check("t6_resync_red", 32'(lamps), 32'h924);
        drive(pat(0, GRN));
        check("t6_resync_pass", 32'(lamps), 32'(pat(0, GRN)));

        // T3: east green one sample short
        hold(pat(0, YEL), 4);
        hold(pat(2, GRN), 7);
        drive(pat(2, YEL));
        expect_fault("t3_short_green", 3'd4, 2'd2);
        clear_fault();
        sync_north();
        hold(pat(0, YEL), 4);
        hold(pat(2, GRN), 8);
        drive(pat(2, YEL));
        check("t3_exact_green", 32'(fault), 32'd0);
        check("t3_exact_lamp", 32'(lamps), 32'(pat(2, YEL)));
        fault_clr = 1'b1;                  // ignored outside flashing
        drive(pat(2, YEL));
        fault_clr = 1'b0;
        check("clr_ignored", 32'(lamps), 32'(pat(2, YEL)));
        hold(pat(2, YEL), 2);

        // T4: west yellow back to green, then bad encoding with a conflict
        hold(pat(3, GRN), 8);
        drive(pat(3, YEL));
        drive(pat(3, GRN));
        expect_fault("t4_bad_trans", 3'd3, 2'd3);
        clear_fault();
        sync_north();
        p = pat(0, GRN); p[11:9] = 3'b011;
        drive(p);
        expect_fault("t4_bad_enc", 3'd1, 2'd3);
        clear_fault();

        // T5: all-red run of two tolerated, three faults
        sync_north();
        hold(pat(0, YEL), 4);
        hold({4{RED}}, 2);
        check("t5_two_red", 32'(fault), 32'd0);
        drive(pat(1, GRN));
        check("t5_after_red", 32'(lamps), 32'(pat(1, GRN)));
        hold(pat(1, GRN), 7);
        hold(pat(1, YEL), 4);
        hold({4{RED}}, 2);
        drive({4{RED}});
        expect_fault("t5_timeout", 3'd6, 2'd0);

        // T6b: reset during the dark half of flashing
        hold({4{RED}}, 5);
        check("t6_flash_dark", 32'(lamps), 32'h000);
        rst_a = 1'b0;
        drive({4{RED}});
        rst_a = 1'b1;
        check("t6_rst_lamps", 32'(lamps), 32'h924);
        check("t6_rst_fault", 32'(fault), 32'd0);
        check("t6_rst_code", 32'(fault_code), 32'd0);

        // short yellow on an armed direction
        sync_north();
        hold(pat(0, YEL), 4);
        hold(pat(1, GRN), 8);
        hold(pat(1, YEL), 3);
        drive({4{RED}});
        expect_fault("short_yellow", 3'd5, 2'd1);
        clear_fault();

        // long green must saturate rather than wrap
        sync_north();
        hold(pat(0, YEL), 4);
        hold(pat(1, GRN), 258);
        drive(pat(1, YEL));
        check("sat_green", 32'(fault), 32'd0);

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
